// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - request, response and multiplier-side signal bundle for mult_issue_ctrl
//
// Purpose: groups the three channels around the issue controller.
//   req_*  : operand pair + tag into the controller (valid/ready)
//   rsp_*  : product + tag + timeout flag out of the controller (valid/ready)
//   mul_*  : enable/operand bus to, and busy/product bus from, the sign_mult core
// Modports:
//   slave  : the controller side (mult_issue_ctrl)
//   master : the environment side (requester, consumer and multiplier)

interface mult_issue_ctrl_if #(
   parameter int TAG_W = 4
) ();

   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_a;
   logic [31:0]       req_b;
   logic [TAG_W-1:0]  req_tag;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [63:0]       rsp_product;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_timeout;

   logic              mul_enable;
   logic [63:0]       mul_operands;
   logic              mul_busy;
   logic [63:0]       mul_product;

   modport slave (
      input  req_valid, req_a, req_b, req_tag,
      output req_ready,
      output rsp_valid, rsp_product, rsp_tag, rsp_timeout,
      input  rsp_ready,
      output mul_enable, mul_operands,
      input  mul_busy, mul_product
   );

   modport master (
      output req_valid, req_a, req_b, req_tag,
      input  req_ready,
      input  rsp_valid, rsp_product, rsp_tag, rsp_timeout,
      output rsp_ready,
      input  mul_enable, mul_operands,
      output mul_busy, mul_product
   );

endinterface

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - single-outstanding issue sequencer in front of the sign_mult Booth multiplier
//
// Purpose: accepts one operand pair at a time, launches the multiplier with a
// one-cycle enable, holds the operand bus stable for the whole iteration,
// captures the product when busy falls (or when the busy watchdog expires)
// and returns it with its tag on the response channel.
// Ports:
//   clock_in   : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   bus.req_*  : request channel (valid/ready, signed a/b, tag)
//   bus.rsp_*  : response channel (valid/ready, 64-bit product, tag, timeout)
//   bus.mul_*  : multiplier control (enable pulse, operand bus, busy, product)
// Parameters:
//   TAG_W          : tag width
//   TIMEOUT_CYCLES : busy cycles tolerated in WAIT before a forced timeout
//                    response; keep it >= 33 so a healthy 32-iteration
//                    multiply never trips it.

module mult_issue_ctrl #(
   parameter int TAG_W          = 4,
   parameter int TIMEOUT_CYCLES = 40
) (
   input  logic              clock_in,
   input  logic              reset_n,
   mult_issue_ctrl_if.slave  bus
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [63:0]       operands_q;
   logic [TAG_W-1:0]  tag_q;
   logic [63:0]       product_q;
   logic [TAG_W-1:0]  rsp_tag_q;
   logic              timeout_q;
   logic [WD_W-1:0]   watchdog_q;

   logic              accept;
   logic              capture;
   logic              timeout_hit;
   logic              req_ready_c;
   logic              mul_enable_c;
   logic              rsp_valid_c;

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------
   // Next-state and control outputs
   // -------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      req_ready_c  = 1'b0;
      mul_enable_c = 1'b0;
      rsp_valid_c  = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      timeout_hit  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Gating with reset_n keeps ready low while reset is held.
            // Gating with mul_busy keeps a stuck or still-running multiplier
            // (after a timeout or a mid-operation reset) from being relaunched.
            req_ready_c = reset_n && !bus.mul_busy;
            if (bus.req_valid && req_ready_c) begin
               accept  = 1'b1;
               state_d = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            mul_enable_c = 1'b1;
            state_d      = S_WAIT;
         end

         S_WAIT: begin
            if (!bus.mul_busy) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else if (watchdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               // This busy cycle is the TIMEOUT_CYCLES-th one: give up.
               capture     = 1'b1;
               timeout_hit = 1'b1;
               state_d     = S_RESP;
            end
         end

         S_RESP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Datapath: operand/tag hold, watchdog, response capture
   // -------------------------------------------------------------------
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         operands_q <= '0;
         tag_q      <= '0;
         product_q  <= '0;
         rsp_tag_q  <= '0;
         timeout_q  <= 1'b0;
         watchdog_q <= '0;
      end else begin
         // Operands are only loaded on acceptance, so the bus stays frozen
         // from LAUNCH until the response has been taken; the multiplier
         // re-reads the multiplicand on every iteration.
         if (accept) begin
            operands_q <= {bus.req_a, bus.req_b};
            tag_q      <= bus.req_tag;
         end

         if (state_q == S_LAUNCH) begin
            watchdog_q <= '0;
         end else if (state_q == S_WAIT && bus.mul_busy) begin
            watchdog_q <= watchdog_q + WD_W'(1);
         end

         // Response fields change only on capture, so they are stable for
         // the whole time rsp_valid is waiting on rsp_ready.
         if (capture) begin
            product_q <= bus.mul_product;
            rsp_tag_q <= tag_q;
            timeout_q <= timeout_hit;
         end
      end
   end

   // -------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------
   assign bus.req_ready    = req_ready_c;
   assign bus.mul_enable   = mul_enable_c;
   assign bus.mul_operands = operands_q;
   assign bus.rsp_valid    = rsp_valid_c;
   assign bus.rsp_product  = product_q;
   assign bus.rsp_tag      = rsp_tag_q;
   assign bus.rsp_timeout  = timeout_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - directed self-checking bench for mult_issue_ctrl

module tb_mult_issue_ctrl;

   localparam logic [63:0] HANG_PROD = 64'hDEAD_BEEF_0000_0001;

   logic clk;
   logic rst_n;

   mult_issue_ctrl_if #(.TAG_W(4)) bus ();

   mult_issue_ctrl #(.TAG_W(4), .TIMEOUT_CYCLES(40)) dut (
      .clock_in (clk),
      .reset_n  (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sign_mult stand-in: enable sampled at one edge, 32 iteration
   // edges, busy drops at the last one. Product is formed from the operand bus
   // at the final iteration, so an unstable bus yields a wrong product.
   logic        m_busy = 1'b0;
   logic [5:0]  m_cnt  = '0;
   logic [63:0] m_prod = '0;
   logic        hang   = 1'b0;

   always @(posedge clk) begin
      if (bus.mul_enable && !m_busy) begin
         m_busy <= 1'b1;
         m_cnt  <= 6'd32;
      end else if (m_busy) begin
         if (hang) begin
            m_prod <= HANG_PROD;
            m_cnt  <= 6'd1;
         end else begin
            m_cnt <= m_cnt - 6'd1;
            if (m_cnt == 6'd1) begin
               m_busy <= 1'b0;
               m_prod <= $signed({{32{bus.mul_operands[63]}}, bus.mul_operands[63:32]}) *
                         $signed({{32{bus.mul_operands[31]}}, bus.mul_operands[31:0]});
            end
         end
      end
   end

   assign bus.mul_busy    = m_busy;
   assign bus.mul_product = m_prod;

   int en_count      = 0;
   int en_while_busy = 0;
   always @(negedge clk) begin
      if (bus.mul_enable) en_count++;
      if (bus.mul_enable && bus.mul_busy) en_while_busy++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents a request and returns #1 after its acceptance edge (E0).
   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t);
      int guard;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = t;
      bus.req_valid = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, "_accept"}, 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Counts edges after E0 until rsp_valid is seen; -1 if it never comes.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.rsp_valid) lat = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got stalled expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      int e0;
      int bad;
      logic [63:0] ops_exp;

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_tag    = '0;
      bus.rsp_ready  = 1'b1;

      // ---------------- reset state ----------------
      #12;
      check("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
      check("rst_req_ready",   64'(bus.req_ready),   64'd0);
      check("rst_mul_enable",  64'(bus.mul_enable),  64'd0);
      check("rst_operands",    bus.mul_operands,     64'd0);
      check("rst_product",     bus.rsp_product,      64'd0);
      check("rst_tag",         64'(bus.rsp_tag),     64'd0);
      check("rst_timeout",     64'(bus.rsp_timeout), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("idle_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;

      // ---------------- basic 3*5 ----------------
      e0 = en_count;
      send("basic", 32'd3, 32'd5, 4'd1);
      wait_rsp(lat);
      check("basic_latency", 64'(lat),             64'd34);
      check("basic_product", bus.rsp_product,      64'h0000_0000_0000_000F);
      check("basic_tag",     64'(bus.rsp_tag),     64'd1);
      check("basic_timeout", 64'(bus.rsp_timeout), 64'd0);
      check("basic_enables", 64'(en_count - e0),   64'd1);
      @(posedge clk); #1;
      check("basic_rsp_drop", 64'(bus.rsp_valid), 64'd0);
      check("basic_idle_rdy", 64'(bus.req_ready), 64'd1);

      // ---------------- signed ----------------
      send("neg", 32'hFFFF_FFF9, 32'd6, 4'd2);
      wait_rsp(lat);
      check("neg_latency", 64'(lat),        64'd34);
      check("neg_product", bus.rsp_product, 64'hFFFF_FFFF_FFFF_FFD6);
      @(posedge clk); #1;
      send("minmin", 32'h8000_0000, 32'h8000_0000, 4'd9);
      wait_rsp(lat);
      check("minmin_product", bus.rsp_product,  64'h4000_0000_0000_0000);
      check("minmin_tag",     64'(bus.rsp_tag), 64'd9);
      @(posedge clk); #1;

      // ---------------- backpressure ----------------
      bus.rsp_ready = 1'b0;
      send("bp", 32'd10, 32'hFFFF_FFFD, 4'd3);
      wait_rsp(lat);
      check("bp_latency", 64'(lat), 64'd34);
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd200;
      bus.req_tag   = 4'd5;
      bus.req_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.rsp_product !== 64'hFFFF_FFFF_FFFF_FFE2 || bus.rsp_tag !== 4'd3 ||
             bus.rsp_timeout !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0)
            bad++;
         @(posedge clk); #1;
      end
      check("bp_hold_cycles", 64'(bad),           64'd0);
      check("bp_valid_held",  64'(bus.rsp_valid), 64'd1);
      check("bp_product",     bus.rsp_product,    64'hFFFF_FFFF_FFFF_FFE2);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_rsp",   64'(bus.rsp_valid),  64'd0);
      check("bp_idle_rdy",   64'(bus.req_ready),  64'd1);
      check("bp_no_launch",  64'(bus.mul_enable), 64'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("bp2_enable",   64'(bus.mul_enable), 64'd1);
      check("bp2_operands", bus.mul_operands,    {32'd100, 32'd200});
      wait_rsp(lat);
      check("bp2_latency", 64'(lat),         64'd34);
      check("bp2_product", bus.rsp_product,  64'd20000);
      check("bp2_tag",     64'(bus.rsp_tag), 64'd5);
      @(posedge clk); #1;

      // ---------------- operand hold ----------------
      ops_exp = {-32'sd1234, 32'sd5678};
      send("hold", -32'sd1234, 32'sd5678, 4'd7);
      bad = 0;
      lat = 0;
      while (!bus.rsp_valid && lat < 100) begin
         bus.req_a = $urandom;
         bus.req_b = $urandom;
         if (bus.mul_operands !== ops_exp) bad++;
         @(posedge clk); #1;
         lat++;
      end
      check("hold_operands", 64'(bad),        64'd0);
      check("hold_latency",  64'(lat),        64'd34);
      check("hold_product",  bus.rsp_product, -64'sd7006652);
      @(posedge clk); #1;

      // ---------------- watchdog timeout ----------------
      hang = 1'b1;
      e0 = en_count;
      send("tmo", 32'd4, 32'd4, 4'd6);
      wait_rsp(lat);
      check("tmo_latency", 64'(lat),             64'd41);
      check("tmo_flag",    64'(bus.rsp_timeout), 64'd1);
      check("tmo_product", bus.rsp_product,      HANG_PROD);
      check("tmo_tag",     64'(bus.rsp_tag),     64'd6);
      bus.req_a     = 32'd1;
      bus.req_b     = 32'd1;
      bus.req_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) bad++;
      end
      check("tmo_blocked", 64'(bad),            64'd0);
      check("tmo_enables", 64'(en_count - e0),  64'd1);
      bus.req_valid = 1'b0;
      hang = 1'b0;
      @(posedge clk); #1;
      check("tmo_release_rdy", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;

      // ---------------- asynchronous reset mid-operation ----------------
      send("rst", 32'd9, 32'd9, 4'd2);
      repeat (11) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_rsp_valid",  64'(bus.rsp_valid),  64'd0);
      check("arst_mul_enable", 64'(bus.mul_enable), 64'd0);
      check("arst_req_ready",  64'(bus.req_ready),  64'd0);
      #20;
      rst_n = 1'b1;
      #1;
      check("arst_busy_rdy", 64'(bus.req_ready), 64'd0);
      bad = 0;
      lat = 0;
      while (bus.mul_busy && lat < 100) begin
         if (bus.rsp_valid || bus.req_ready) bad++;
         @(posedge clk); #1;
         lat++;
      end
      check("arst_discarded", 64'(bad),           64'd0);
      check("arst_free_rdy",  64'(bus.req_ready), 64'd1);
      send("post", 32'd2, 32'hFFFF_FFFF, 4'd4);
      wait_rsp(lat);
      check("post_latency", 64'(lat),             64'd34);
      check("post_product", bus.rsp_product,      64'hFFFF_FFFF_FFFF_FFFE);
      check("post_tag",     64'(bus.rsp_tag),     64'd4);
      check("post_timeout", 64'(bus.rsp_timeout), 64'd0);
      @(posedge clk); #1;

      check("enable_while_busy", 64'(en_while_busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
